// File: rtl/m_imem_mp.sv
// ---------------------------------------------------------------------------
// m_imem_mp -- multi-port instruction memory with a streaming loader.
//
// NUM_PORTS independent synchronous read ports, one per core fetch stage.
// Each port has request/valid handshaking and a per-port stall that freezes
// its response registers. A loader FSM accepts a word stream and writes it
// from address 0 upwards, so a program can be replaced at run time.
//
// Ports:
//   clk_i, rst_ni         clock (posedge) and asynchronous active-low reset
//   req_i   [P]           per-port read request
//   addr_i  [P*32]        byte addresses, port p = [32p+31:32p]
//   stall_i [P]           per-port hold of rdata/rvalid/rerr
//   rdata_o [P*32]        read data, port p = [32p+31:32p]
//   rvalid_o[P]           response valid
//   rerr_o  [P]           last accepted request was misaligned/out of range
//   ld_start_i            start a load (only acted on in IDLE)
//   ld_len_i [ADDRW+1]    words to load, sampled with ld_start_i
//   ld_valid_i, ld_data_i loader word stream
//   ld_ready_o, ld_busy_o high while loading
//   ld_done_o             one-cycle pulse after the load completes
// ---------------------------------------------------------------------------
module m_imem_mp #(
  parameter int    NUM_PORTS = 2,
  parameter int    ENTRIES   = 4096,
  parameter int    ADDRW     = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_PORTS-1:0]   req_i,
  input  logic [NUM_PORTS*32-1:0] addr_i,
  input  logic [NUM_PORTS-1:0]   stall_i,
  output logic [NUM_PORTS*32-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]   rvalid_o,
  output logic [NUM_PORTS-1:0]   rerr_o,
  input  logic                   ld_start_i,
  input  logic [ADDRW:0]         ld_len_i,
  input  logic                   ld_valid_i,
  input  logic [31:0]            ld_data_i,
  output logic                   ld_ready_o,
  output logic                   ld_busy_o,
  output logic                   ld_done_o
);

  localparam logic [31:0]    NOP     = 32'h0000_0013;
  localparam logic [ADDRW:0] MAX_LEN = (ADDRW+1)'(ENTRIES);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t         state;
  logic [ADDRW:0] len;
  logic [ADDRW:0] cnt;
  logic [ADDRW:0] cnt_inc;
  logic           wr_en;
  logic           loading;

  logic [31:0] mem [ENTRIES];

  assign loading = (state == LOAD);
  assign wr_en   = loading && ld_valid_i;
  assign cnt_inc = cnt + 1'b1;

  // Loader write port. Reads are only served in IDLE and writes only happen
  // in LOAD, so read/write collisions cannot occur.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[cnt[ADDRW-1:0]] <= ld_data_i;
    end
  end

  // Loader FSM with registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      ld_ready_o <= 1'b0;
      ld_busy_o  <= 1'b0;
      ld_done_o  <= 1'b0;
    end else begin
      ld_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start_i) begin
            // A request longer than the memory is clamped to its depth.
            len <= (ld_len_i > MAX_LEN) ? MAX_LEN : ld_len_i;
            cnt <= '0;
            if (ld_len_i == '0) begin
              ld_done_o <= 1'b1;
            end else begin
              state      <= LOAD;
              ld_ready_o <= 1'b1;
              ld_busy_o  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_valid_i) begin
            cnt <= cnt_inc;
            if (cnt_inc == len) begin
              state      <= IDLE;
              ld_ready_o <= 1'b0;
              ld_busy_o  <= 1'b0;
              ld_done_o  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read ports: one response register set per port.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [31:0] addr;
      logic        bad;
      logic [31:0] rdata_q;
      logic        rvalid_q;
      logic        rerr_q;

      assign addr = addr_i[32*gi +: 32];
      // Misaligned, or beyond the last word of the array.
      assign bad  = (addr[1:0] != 2'b00) || (addr[31:ADDRW+2] != '0);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
          rerr_q   <= 1'b0;
        end else if (!stall_i[gi]) begin
          if (loading) begin
            rvalid_q <= 1'b0;
          end else begin
            rvalid_q <= req_i[gi];
            if (req_i[gi]) begin
              rerr_q  <= bad;
              rdata_q <= bad ? NOP : mem[addr[ADDRW+1:2]];
            end
          end
        end
      end

      assign rdata_o[32*gi +: 32] = rdata_q;
      assign rvalid_o[gi]         = rvalid_q;
      assign rerr_o[gi]           = rerr_q;
    end
  endgenerate

endmodule
